// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes and the FSM state type.
package flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    IGNORE
  } state_t;

endpackage

// File: rtl/sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, reset (async, active-high), d (async input), q (synchronized output).
// RST_VAL sets the level both flops take during reset.
module sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// Flash-device end of a single-bit SPI (mode 0) link. Decodes READ and RDID,
// returns data on flash_io1, and fetches read bytes over a valid/ready port.
// Ports:
//   clk, reset                 system clock, async active-high reset
//   flash_clk/csn/io0          SPI pins from the initiator (async to clk)
//   flash_io1_out/en           MISO data and output enable
//   mem_valid/addr/ready/rdata byte read port (1-deep buffer, 1 outstanding)
//   underrun                   1-cycle pulse when a byte is loaded with none buffered
module spi_flash_responder
  import flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016,
  parameter int unsigned ADDR_BITS = 24,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flash_clk,
  input  logic                 flash_csn,
  input  logic                 flash_io0,
  output logic                 flash_io1_out,
  output logic                 flash_io1_en,
  output logic                 mem_valid,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [7:0]           mem_rdata,
  output logic                 underrun
);

  localparam int unsigned CNT_W = $clog2(ADDR_BITS + 1);

  logic sclk_s, csn_s, io0_s;
  logic sclk_q, sclk_q2, io0_q, csn_q;
  logic sclk_rise_c, sclk_fall_c;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [ADDR_BITS-1:0] sh_in, sh_in_nxt;
  logic [7:0]           sh_out, sh_out_nxt;
  logic [2:0]           out_cnt, out_cnt_nxt;
  logic [1:0]           id_idx, id_idx_nxt;
  logic                 buf_valid, buf_valid_nxt;
  logic [7:0]           buf_data, buf_data_nxt;
  logic                 fetch_en, fetch_en_nxt;
  logic [ADDR_BITS-1:0] fetch_addr, fetch_addr_nxt;
  logic                 discard, discard_nxt;
  logic                 mem_valid_nxt;
  logic [ADDR_BITS-1:0] mem_addr_nxt;
  logic                 io1_out_nxt, io1_en_nxt, underrun_nxt;
  logic [7:0]           cmd_byte, load_byte;

  sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(flash_clk), .q(sclk_s));
  sync #(.RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .reset(reset), .d(flash_csn), .q(csn_s));
  sync #(.RST_VAL(1'b0)) u_sync_io0  (.clk(clk), .reset(reset), .d(flash_io0), .q(io0_s));

  // Edges come from the registered synced SCLK; io0 is delayed to stay aligned.
  assign sclk_rise_c = ~csn_s & sclk_q & ~sclk_q2;
  assign sclk_fall_c = ~csn_s & ~sclk_q & sclk_q2;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q        <= 1'b0;
      sclk_q2       <= 1'b0;
      io0_q         <= 1'b0;
      csn_q         <= 1'b1;
      state         <= IDLE;
      bit_cnt       <= '0;
      sh_in         <= '0;
      sh_out        <= '0;
      out_cnt       <= '0;
      id_idx        <= '0;
      buf_valid     <= 1'b0;
      buf_data      <= '0;
      fetch_en      <= 1'b0;
      fetch_addr    <= '0;
      discard       <= 1'b0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      flash_io1_out <= 1'b0;
      flash_io1_en  <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sclk_q        <= sclk_s;
      sclk_q2       <= sclk_q;
      io0_q         <= io0_s;
      csn_q         <= csn_s;
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      sh_in         <= sh_in_nxt;
      sh_out        <= sh_out_nxt;
      out_cnt       <= out_cnt_nxt;
      id_idx        <= id_idx_nxt;
      buf_valid     <= buf_valid_nxt;
      buf_data      <= buf_data_nxt;
      fetch_en      <= fetch_en_nxt;
      fetch_addr    <= fetch_addr_nxt;
      discard       <= discard_nxt;
      mem_valid     <= mem_valid_nxt;
      mem_addr      <= mem_addr_nxt;
      flash_io1_out <= io1_out_nxt;
      flash_io1_en  <= io1_en_nxt;
      underrun      <= underrun_nxt;
    end
  end

  // Next-state, shifting, buffer and fetch logic.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    sh_in_nxt      = sh_in;
    sh_out_nxt     = sh_out;
    out_cnt_nxt    = out_cnt;
    id_idx_nxt     = id_idx;
    buf_valid_nxt  = buf_valid;
    buf_data_nxt   = buf_data;
    fetch_en_nxt   = fetch_en;
    fetch_addr_nxt = fetch_addr;
    discard_nxt    = discard;
    mem_valid_nxt  = mem_valid & ~mem_ready;
    mem_addr_nxt   = mem_addr;
    io1_out_nxt    = flash_io1_out;
    io1_en_nxt     = flash_io1_en;
    underrun_nxt   = 1'b0;
    cmd_byte       = {sh_in[6:0], io0_q};
    load_byte      = FILL_BYTE;

    // Completed handshake: fill the buffer unless the request belongs to an aborted transfer.
    if (mem_valid && mem_ready) begin
      if (discard) begin
        discard_nxt = 1'b0;
      end else begin
        buf_valid_nxt = 1'b1;
        buf_data_nxt  = mem_rdata;
      end
    end

    if (csn_s) begin
      state_nxt     = IDLE;
      io1_en_nxt    = 1'b0;
      io1_out_nxt   = 1'b0;
      fetch_en_nxt  = 1'b0;
      buf_valid_nxt = 1'b0;
      if (mem_valid_nxt) begin
        discard_nxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (csn_q) begin
            state_nxt   = CMD;
            bit_cnt_nxt = '0;
            out_cnt_nxt = '0;
            id_idx_nxt  = '0;
          end
        end
        CMD: begin
          if (sclk_rise_c) begin
            sh_in_nxt   = {sh_in[ADDR_BITS-2:0], io0_q};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt_nxt = '0;
              if (cmd_byte == CMD_READ) begin
                state_nxt = ADDR;
              end else if (cmd_byte == CMD_RDID) begin
                state_nxt = ID;
              end else begin
                state_nxt = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          if (sclk_rise_c) begin
            sh_in_nxt   = {sh_in[ADDR_BITS-2:0], io0_q};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
              state_nxt      = DATA;
              fetch_en_nxt   = 1'b1;
              fetch_addr_nxt = {sh_in[ADDR_BITS-2:0], io0_q};
            end
          end
        end
        DATA, ID: begin
          if (sclk_fall_c) begin
            io1_en_nxt = 1'b1;
            if (out_cnt == 3'd0) begin
              // Byte boundary: pick the next byte from the buffer or the ID sequence.
              if (state == ID) begin
                case (id_idx)
                  2'd0:    load_byte = JEDEC_ID[23:16];
                  2'd1:    load_byte = JEDEC_ID[15:8];
                  default: load_byte = JEDEC_ID[7:0];
                endcase
                id_idx_nxt = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
              end else if (buf_valid) begin
                load_byte     = buf_data;
                buf_valid_nxt = 1'b0;
              end else begin
                underrun_nxt = 1'b1;
              end
              io1_out_nxt = load_byte[7];
              sh_out_nxt  = {load_byte[6:0], 1'b0};
              out_cnt_nxt = 3'd7;
            end else begin
              io1_out_nxt = sh_out[7];
              sh_out_nxt  = {sh_out[6:0], 1'b0};
              out_cnt_nxt = out_cnt - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end

    // Prefetch whenever reading, the buffer is empty and the port is idle.
    if (fetch_en_nxt && !buf_valid_nxt && !mem_valid_nxt) begin
      mem_valid_nxt  = 1'b1;
      mem_addr_nxt   = fetch_addr_nxt;
      fetch_addr_nxt = fetch_addr_nxt + ADDR_BITS'(1);
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: an SPI mode-0 initiator, a
// behavioural byte memory, and expectations derived from address arithmetic.
module tb_spi_flash_responder;

  localparam int HP = 8;  // SCLK half period in clk cycles

  logic        clk;
  logic        reset;
  logic        flash_clk, flash_csn, flash_io0;
  logic        flash_io1_out, flash_io1_en;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        underrun;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]  mem_tab [256];
  logic [23:0] req_q [$];
  int          mem_lat   = 0;
  logic        mem_stall = 1'b0;
  int          underrun_cnt = 0;
  int          valid_cyc    = 0;
  logic        en_seen      = 1'b0;
  logic [7:0]  rx_bytes [8];

  spi_flash_responder dut (
    .clk          (clk),
    .reset        (reset),
    .flash_clk    (flash_clk),
    .flash_csn    (flash_csn),
    .flash_io0    (flash_io0),
    .flash_io1_out(flash_io1_out),
    .flash_io1_en (flash_io1_en),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_fn(input logic [23:0] a);
    logic [7:0] idx;
    idx = a[7:0] ^ a[15:8] ^ a[23:16];
    return mem_tab[idx];
  endfunction

  function automatic logic [31:0] get_req(input int i);
    if (req_q.size() > i) return {8'h00, req_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] id_byte(input int k);
    logic [23:0] id;
    id = 24'hEF4016;
    return 8'(id >> (8 * (2 - (k % 3))));
  endfunction

  // Memory model: answers each request after mem_lat waiting cycles unless stalled.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (mem_valid && !mem_stall) begin
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          req_q.push_back(mem_addr);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Activity monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (underrun)     underrun_cnt++;
      if (mem_valid)    valid_cyc++;
      if (flash_io1_en) en_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    underrun_cnt = 0;
    valid_cyc    = 0;
    en_seen      = 1'b0;
    req_q.delete();
  endtask

  task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      flash_io0 = tx[i];
      repeat (HP) @(posedge clk);
      #1;
      rx = {rx[30:0], flash_io1_out};
      flash_clk = 1'b1;
      repeat (HP) @(posedge clk);
      #1;
      flash_clk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    flash_csn = 1'b0;
    repeat (HP) @(posedge clk);
    #1;
  endtask

  task automatic cs_end();
    repeat (HP) @(posedge clk);
    #1;
    flash_csn = 1'b1;
    repeat (3 * HP) @(posedge clk);
    #1;
  endtask

  task automatic read_bytes(input int n);
    logic [31:0] rx;
    for (int k = 0; k < n; k++) begin
      spi_bits(32'h0, 8, rx);
      rx_bytes[k] = rx[7:0];
    end
  endtask

  task automatic start_read(input logic [23:0] a);
    logic [31:0] rx;
    logic [31:0] frame;
    frame = {8'h03, a};
    cs_begin();
    spi_bits(frame, 32, rx);
  endtask

  initial begin
    logic [31:0] rx;
    logic [23:0] a;
    int          nb;

    reset = 1'b1;
    flash_clk = 1'b0;
    flash_csn = 1'b1;
    flash_io0 = 1'b0;
    for (int i = 0; i < 256; i++) mem_tab[i] = 8'($urandom);
    mem_tab[8'h10] = 8'hA5;
    mem_tab[8'h11] = 8'h3C;

    repeat (4) @(posedge clk);
    #1;
    check("rst_io1_out",   32'(flash_io1_out), 32'd0);
    check("rst_io1_en",    32'(flash_io1_en),  32'd0);
    check("rst_mem_valid", 32'(mem_valid),     32'd0);
    check("rst_mem_addr",  32'(mem_addr),      32'd0);
    check("rst_underrun",  32'(underrun),      32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // READ 0x000010, two bytes with single-cycle ready.
    clear_mon();
    mem_lat = 0;
    start_read(24'h000010);
    read_bytes(2);
    cs_end();
    check("read10_b0",   32'(rx_bytes[0]), 32'hA5);
    check("read10_b1",   32'(rx_bytes[1]), 32'h3C);
    check("read10_req0", get_req(0), 32'h10);
    check("read10_req1", get_req(1), 32'h11);

    // RDID: ID bytes repeat, memory untouched.
    clear_mon();
    cs_begin();
    spi_bits(32'h9F, 8, rx);
    for (int k = 0; k < 6; k++) begin
      spi_bits(32'h0, 8, rx);
      check($sformatf("rdid_b%0d", k), 32'(rx[7:0]), 32'(id_byte(k)));
    end
    cs_end();
    check("rdid_no_valid", 32'(valid_cyc), 32'd0);

    // Unknown opcode: stays silent.
    clear_mon();
    cs_begin();
    spi_bits(32'h05, 8, rx);
    spi_bits(32'hA5A5, 16, rx);
    cs_end();
    check("ign_en",       32'(en_seen),   32'd0);
    check("ign_no_valid", 32'(valid_cyc), 32'd0);

    // Address wrap at the top of the space.
    clear_mon();
    start_read(24'hFFFFFF);
    read_bytes(2);
    cs_end();
    check("wrap_req0", get_req(0), 32'hFFFFFF);
    check("wrap_req1", get_req(1), 32'h000000);
    check("wrap_b0",   32'(rx_bytes[0]), 32'(mem_fn(24'hFFFFFF)));
    check("wrap_b1",   32'(rx_bytes[1]), 32'(mem_fn(24'h000000)));

    // Underrun: 3 byte loads happen while stalled, then delayed data follows.
    clear_mon();
    a = 24'h00ABC0;
    mem_stall = 1'b1;
    start_read(a);
    read_bytes(2);
    check("ur_b0", 32'(rx_bytes[0]), 32'hFF);
    check("ur_b1", 32'(rx_bytes[1]), 32'hFF);
    repeat (10) @(posedge clk);
    #1;
    mem_stall = 1'b0;
    read_bytes(3);
    cs_end();
    check("ur_b2",    32'(rx_bytes[0]), 32'hFF);
    check("ur_b3",    32'(rx_bytes[1]), 32'(mem_fn(a)));
    check("ur_b4",    32'(rx_bytes[2]), 32'(mem_fn(a + 24'd1)));
    check("ur_count", 32'(underrun_cnt), 32'd3);
    check("ur_req0",  get_req(0), 32'(a));

    // Abort after 12 address bits, then a clean READ 0x000020.
    clear_mon();
    cs_begin();
    spi_bits(32'h03, 8, rx);
    spi_bits(32'h123, 12, rx);
    cs_end();
    check("abort_no_valid", 32'(valid_cyc), 32'd0);
    start_read(24'h000020);
    read_bytes(1);
    cs_end();
    check("restart_req0", get_req(0), 32'h20);
    check("restart_b0",   32'(rx_bytes[0]), 32'(mem_fn(24'h000020)));

    // Randomized reads with random memory latency.
    for (int t = 0; t < 8; t++) begin
      clear_mon();
      a       = 24'($urandom);
      nb      = $urandom_range(1, 4);
      mem_lat = $urandom_range(0, 3);
      start_read(a);
      read_bytes(nb);
      cs_end();
      check($sformatf("rnd%0d_req0", t), get_req(0), 32'(a));
      for (int k = 0; k < nb; k++)
        check($sformatf("rnd%0d_b%0d", t, k), 32'(rx_bytes[k]), 32'(mem_fn(a + 24'(k))));
      check($sformatf("rnd%0d_ur", t), 32'(underrun_cnt), 32'd0);
    end

    // Reset in the middle of DATA clears outputs at once.
    mem_lat = 0;
    start_read(24'h000040);
    read_bytes(1);
    spi_bits(32'h0, 3, rx);
    check("mid_en_before", 32'(flash_io1_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_io1_out",   32'(flash_io1_out), 32'd0);
    check("mid_io1_en",    32'(flash_io1_en),  32'd0);
    check("mid_mem_valid", 32'(mem_valid),     32'd0);
    check("mid_mem_addr",  32'(mem_addr),      32'd0);
    check("mid_underrun",  32'(underrun),      32'd0);
    flash_csn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
